// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic tile scheduler slice.
//   - sched_state_t : FSM state encoding (IDLE=0, CLEAR=1, FEED=2, DRAIN=3,
//                     DONE=4), 3 bits wide
//   - DEFAULT_ARRAY_SIZE / DEFAULT_K_WIDTH : default geometry used by the
//                     scheduler and the skew-mask generator
// No ports (package only).
// ---------------------------------------------------------------------------
package systolic_pkg;

  // Default PE array edge length (rows == columns).
  localparam int DEFAULT_ARRAY_SIZE = 16;

  // Default width of the reduction length K.
  localparam int DEFAULT_K_WIDTH = 16;

  // Scheduler FSM states. The encoding is fixed so that other blocks
  // (debug taps, perf counters) can decode the state register directly.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

endpackage : systolic_pkg

// File: rtl/systolic_skew_mask.sv
// ---------------------------------------------------------------------------
// systolic_skew_mask
// Purely combinational skew-mask generator for a systolic array feeder.
// Lane i (row i of A, column i of B) is active for step t when
//   i <= t < i + K
// which produces the diagonal wavefront a systolic array expects: lane 0
// starts first, each further lane starts one step later, and every lane is
// active for exactly K consecutive steps.
//
// Ports:
//   t      in  K_WIDTH+1   current feed step
//   k      in  K_WIDTH     reduction length K
//   active out ARRAY_SIZE  per-lane active mask
// ---------------------------------------------------------------------------
module systolic_skew_mask
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
  parameter int K_WIDTH    = DEFAULT_K_WIDTH
) (
  input  logic [K_WIDTH:0]      t,
  input  logic [K_WIDTH-1:0]    k,
  output logic [ARRAY_SIZE-1:0] active
);

  // The window bounds are evaluated one bit wider than t so that i + K
  // cannot wrap even for the largest K and the last lane.
  logic [K_WIDTH+1:0] t_ext;
  logic [K_WIDTH+1:0] lane_lo;
  logic [K_WIDTH+1:0] lane_hi;

  assign t_ext = {1'b0, t};

  // Build the mask one lane at a time: lane i opens at step i and closes
  // K steps later. With K = 0 the window is empty and no lane is active.
  always_comb begin
    active  = '0;
    lane_lo = '0;
    lane_hi = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      lane_lo   = (K_WIDTH + 2)'(i);
      lane_hi   = lane_lo + {2'b00, k};
      active[i] = (t_ext >= lane_lo) && (t_ext < lane_hi);
    end
  end

endmodule : systolic_skew_mask

// File: rtl/systolic_tile_scheduler.sv
// ---------------------------------------------------------------------------
// systolic_tile_scheduler
// Sequences one output tile through an ARRAY_SIZE x ARRAY_SIZE systolic
// array: clears the PE accumulators, streams skewed A rows / B columns out
// of their operand FIFOs for K reduction steps, waits for the wavefront to
// drain through the array, then pulses done.
//
// Any active lane whose A or B FIFO is empty stalls the whole array for
// that cycle (no lane pops, the step counter holds), so the skew between
// lanes is never disturbed.
//
// Ports:
//   clk          in   1           clock
//   rst          in   1           synchronous active-high reset
//   start        in   1           begin a tile (sampled in IDLE only)
//   k_len        in   K_WIDTH     reduction length, latched on accepted start
//   a_empty      in   ARRAY_SIZE  per-row operand-A FIFO empty flags
//   b_empty      in   ARRAY_SIZE  per-column operand-B FIFO empty flags
//   a_pop        out  ARRAY_SIZE  per-row A pop / array A-lane valid
//   b_pop        out  ARRAY_SIZE  per-column B pop / array B-lane valid
//   array_clear  out  1           clear all PE accumulators
//   busy         out  1           tile in progress
//   done         out  1           one-cycle tile-complete pulse
//   stall_cycles out  32          FEED stall cycles of the current tile
//                                 (only when SYSTOLIC_SCHED_PERF_EN is
//                                 defined)
//
// Build option:
//   SYSTOLIC_SCHED_PERF_EN  adds the stall_cycles port and its saturating
//                           counter; without it the port does not exist.
// ---------------------------------------------------------------------------
module systolic_tile_scheduler
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = DEFAULT_ARRAY_SIZE,
  parameter int K_WIDTH    = DEFAULT_K_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [K_WIDTH-1:0]    k_len,
  input  logic [ARRAY_SIZE-1:0] a_empty,
  input  logic [ARRAY_SIZE-1:0] b_empty,
  output logic [ARRAY_SIZE-1:0] a_pop,
  output logic [ARRAY_SIZE-1:0] b_pop,
  output logic                  array_clear,
  output logic                  busy,
  output logic                  done
`ifdef SYSTOLIC_SCHED_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int DRAIN_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  sched_state_t        state;
  sched_state_t        state_next;

  logic [K_WIDTH-1:0]  k_reg;
  logic [K_WIDTH-1:0]  k_next;

  // t is one bit wider than K so that the last step K+ARRAY_SIZE-2 and the
  // increment past it never wrap.
  logic [K_WIDTH:0]    t;
  logic [K_WIDTH:0]    t_next;
  logic [K_WIDTH:0]    feed_last;

  logic [DRAIN_W-1:0]  drain_cnt;
  logic [DRAIN_W-1:0]  drain_next;

  logic [ARRAY_SIZE-1:0] lane_active;
  logic [ARRAY_SIZE-1:0] feed_mask;
  logic                  stall;

  // Diagonal wavefront mask for the current step and latched K.
  systolic_skew_mask #(
    .ARRAY_SIZE (ARRAY_SIZE),
    .K_WIDTH    (K_WIDTH)
  ) u_skew_mask (
    .t      (t),
    .k      (k_reg),
    .active (lane_active)
  );

  // The final feed step is the one where the last lane consumes its K-th
  // operand: lane ARRAY_SIZE-1 opens at step ARRAY_SIZE-1 and stays open K
  // steps.
  assign feed_last = {1'b0, k_reg} + (K_WIDTH + 1)'(ARRAY_SIZE - 2);

  // Lanes only count as active while feeding; a stall is raised when any
  // active lane is missing an operand on either side, and then nobody pops
  // so that all lanes stay aligned on the same step.
  assign feed_mask = (state == FEED) ? lane_active : '0;
  assign stall     = |(feed_mask & (a_empty | b_empty));
  assign a_pop     = stall ? '0 : feed_mask;
  assign b_pop     = stall ? '0 : feed_mask;
  assign busy      = (state != IDLE);

  // State, step counter, drain counter and latched K. Reset abandons any
  // tile in flight and returns everything to its idle value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_reg     <= '0;
      t         <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      k_reg     <= k_next;
      t         <= t_next;
      drain_cnt <= drain_next;
    end
  end

  // Next-state and control decode. start is only looked at in IDLE, so a
  // start held through DONE is picked up on the first IDLE cycle after it.
  // K = 0 skips FEED and DRAIN altogether since there is nothing to stream.
  always_comb begin
    state_next  = state;
    k_next      = k_reg;
    t_next      = t;
    drain_next  = drain_cnt;
    array_clear = 1'b0;
    done        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          k_next     = k_len;
          state_next = CLEAR;
        end
      end

      CLEAR: begin
        array_clear = 1'b1;
        t_next      = '0;
        drain_next  = '0;
        state_next  = (k_reg == '0) ? DONE : FEED;
      end

      FEED: begin
        if (!stall) begin
          t_next = t + (K_WIDTH + 1)'(1);
          if (t == feed_last) begin
            drain_next = '0;
            state_next = DRAIN;
          end
        end
      end

      DRAIN: begin
        if (drain_cnt == DRAIN_W'(ARRAY_SIZE - 1)) begin
          state_next = DONE;
        end else begin
          drain_next = drain_cnt + DRAIN_W'(1);
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef SYSTOLIC_SCHED_PERF_EN
  // Per-tile stall counter: cleared when a new tile is accepted, frozen
  // after the tile finishes so software can read it, and saturating rather
  // than wrapping on pathologically starved tiles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cycles <= '0;
    end else if ((state == FEED) && stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule : systolic_tile_scheduler

// File: tb/tb_systolic_tile_scheduler.sv
// ---------------------------------------------------------------------------
// tb_systolic_tile_scheduler
// Directed self-checking bench for systolic_tile_scheduler with
// ARRAY_SIZE=4, K_WIDTH=16. Cycle 0 is the cycle in which start is driven;
// cycle n is observed shortly after the n-th following rising edge.
// Build option: SYSTOLIC_SCHED_PERF_EN also checks stall_cycles.
// ---------------------------------------------------------------------------
module tb_systolic_tile_scheduler;

  localparam int N  = 4;
  localparam int KW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic [N-1:0]  a_empty;
  logic [N-1:0]  b_empty;
  logic [N-1:0]  a_pop;
  logic [N-1:0]  b_pop;
  logic          array_clear;
  logic          busy;
  logic          done;
`ifdef SYSTOLIC_SCHED_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  int checks_run;
  int fail_count;
  int cyc;

  // Hand-derived a_pop/b_pop sequences indexed by cycle number.
  logic [N-1:0] seq_k3    [0:13];
  logic [N-1:0] seq_stall [0:15];
  logic [N-1:0] seq_k2    [0:11];
  logic [N-1:0] seq_k1    [0:11];

  systolic_tile_scheduler #(
    .ARRAY_SIZE (N),
    .K_WIDTH    (KW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .k_len       (k_len),
    .a_empty     (a_empty),
    .b_empty     (b_empty),
    .a_pop       (a_pop),
    .b_pop       (b_pop),
    .array_clear (array_clear),
    .busy        (busy),
    .done        (done)
`ifdef SYSTOLIC_SCHED_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_run++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h",
             tag, cyc, observed, expected);
    end
  endtask

  // Full output check for one cycle.
  task automatic checkCycle(input string tag, input logic exp_clear,
                            input logic exp_busy, input logic exp_done,
                            input logic [N-1:0] exp_pop);
    checkOutput({tag, "_array_clear"}, 32'(array_clear), 32'(exp_clear));
    checkOutput({tag, "_busy"},        32'(busy),        32'(exp_busy));
    checkOutput({tag, "_done"},        32'(done),        32'(exp_done));
    checkOutput({tag, "_a_pop"},       32'(a_pop),       32'(exp_pop));
    checkOutput({tag, "_b_pop"},       32'(b_pop),       32'(exp_pop));
  endtask

  task automatic applyStimulus(input logic s, input logic [KW-1:0] k,
                               input logic [N-1:0] ae, input logic [N-1:0] be,
                               input logic r);
    start   = s;
    k_len   = k;
    a_empty = ae;
    b_empty = be;
    rst     = r;
  endtask

  // Advance to the next cycle and leave time after the edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  int            r;
  int            done_count;
  int            done_cyc;
  int            a_cnt [N];
  int            b_cnt [N];

  initial begin
    checks_run = 0;
    fail_count = 0;
    cyc        = 0;

    seq_k3    = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8,
                  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    seq_stall = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h3, 4'h7, 4'hE,
                  4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    seq_k2    = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h6, 4'hC, 4'h8, 4'h0,
                  4'h0, 4'h0, 4'h0, 4'h0};
    seq_k1    = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0,
                  4'h0, 4'h0, 4'h0, 4'h0};

    // Reset state.
    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkCycle("reset", 1'b0, 1'b0, 1'b0, 4'h0);
`ifdef SYSTOLIC_SCHED_PERF_EN
    checkOutput("reset_stall_cycles", stall_cycles, 32'd0);
`endif
    @(negedge clk);

    // K=3, FIFOs always full.
    $display("[TB] K=3 unstalled tile");
    cyc = 0;
    applyStimulus(1'b1, 16'd3, '0, '0, 1'b0);
    for (int c = 1; c <= 13; c++) begin
      nextCycle();
      applyStimulus(1'b0, 16'd3, '0, '0, 1'b0);
      #1;
      checkCycle("k3", c == 1, c <= 12, c == 12, seq_k3[c]);
    end
`ifdef SYSTOLIC_SCHED_PERF_EN
    checkOutput("k3_stall_cycles", stall_cycles, 32'd0);
`endif

    // K=3 with b_empty[1] during cycles 3..4.
    $display("[TB] K=3 tile with two stall cycles");
    cyc = 0;
    applyStimulus(1'b1, 16'd3, '0, '0, 1'b0);
    for (int c = 1; c <= 15; c++) begin
      nextCycle();
      applyStimulus(1'b0, 16'd3, '0, (c == 3 || c == 4) ? 4'b0010 : 4'b0000, 1'b0);
      #1;
      checkCycle("stall", c == 1, c <= 14, c == 14, seq_stall[c]);
    end
`ifdef SYSTOLIC_SCHED_PERF_EN
    checkOutput("stall_stall_cycles", stall_cycles, 32'd2);
`endif

    // K=0: clear then done, no pops.
    $display("[TB] K=0 tile");
    cyc = 0;
    applyStimulus(1'b1, 16'd0, '0, '0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      nextCycle();
      applyStimulus(1'b0, 16'd0, '0, '0, 1'b0);
      #1;
      checkCycle("k0", c == 1, c <= 2, c == 2, 4'h0);
    end

    // Reset mid-FEED, start with rst ignored, then a K=1 tile from cycle 8.
    $display("[TB] reset during FEED then K=1 tile");
    cyc = 0;
    applyStimulus(1'b1, 16'd3, '0, '0, 1'b0);
    for (int c = 1; c <= 19; c++) begin
      nextCycle();
      if (c == 5)      applyStimulus(1'b0, 16'd3, '0, '0, 1'b1);
      else if (c == 6) applyStimulus(1'b1, 16'd3, '0, '0, 1'b1);
      else if (c == 8) applyStimulus(1'b1, 16'd1, '0, '0, 1'b0);
      else             applyStimulus(1'b0, 16'd1, '0, '0, 1'b0);
      #1;
      if (c <= 5)
        checkCycle("rstmid", c == 1, 1'b1, 1'b0, seq_k3[c]);
      else if (c <= 8)
        checkCycle("rstmid", 1'b0, 1'b0, 1'b0, 4'h0);
      else
        checkCycle("rstmid", c == 9, c <= 18, c == 18, seq_k1[c - 8]);
    end

    // Start held high with K=2: back-to-back tiles, done at 11 and 23.
    $display("[TB] back-to-back K=2 tiles");
    cyc = 0;
    applyStimulus(1'b1, 16'd2, '0, '0, 1'b0);
    for (int c = 1; c <= 25; c++) begin
      nextCycle();
      applyStimulus(c < 24, 16'd2, '0, '0, 1'b0);
      #1;
      if (c >= 24) begin
        checkCycle("b2b", 1'b0, 1'b0, 1'b0, 4'h0);
      end else begin
        r = (c <= 11) ? c : c - 12;
        checkCycle("b2b", r == 1, r != 0, r == 11, seq_k2[r]);
      end
    end

    // K=65535, no stalls: count pops per lane and the done pulse.
    $display("[TB] K=65535 long tile");
    for (int i = 0; i < N; i++) begin
      a_cnt[i] = 0;
      b_cnt[i] = 0;
    end
    done_count = 0;
    done_cyc   = 0;
    cyc        = 0;
    applyStimulus(1'b1, 16'hFFFF, '0, '0, 1'b0);
    for (int c = 1; c <= 70000; c++) begin
      nextCycle();
      applyStimulus(1'b0, 16'hFFFF, '0, '0, 1'b0);
      #1;
      for (int i = 0; i < N; i++) begin
        a_cnt[i] += int'(a_pop[i]);
        b_cnt[i] += int'(b_pop[i]);
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (done_count != 0 && cyc > done_cyc + 3) break;
    end
    checkOutput("k65535_done_count", 32'(done_count), 32'd1);
    checkOutput("k65535_done_cycle", 32'(done_cyc), 32'd65544);
    checkOutput("k65535_busy_after", 32'(busy), 32'd0);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("k65535_a_pops_lane%0d", i), 32'(a_cnt[i]), 32'd65535);
      checkOutput($sformatf("k65535_b_pops_lane%0d", i), 32'(b_cnt[i]), 32'd65535);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks_run, fail_count);
    $finish;
  end

endmodule : tb_systolic_tile_scheduler

// File: doc/systolic_tile_scheduler.md
SYSTOLIC_TILE_SCHEDULER -- requirements
Module: systolic_tile_scheduler

Interface
REQ-001 Parameters SHALL be: ARRAY_SIZE, default 16, PE rows/cols (>=2); K_WIDTH, default 16, width of reduction length.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  reset: one clock, synchronous, active-high.
- start  in  1  begin a tile; sampled in IDLE only.
- k_len  in  K_WIDTH  reduction length K; latched on accepted start.
- a_empty  in  ARRAY_SIZE  per-row operand-A FIFO empty flags.
- b_empty  in  ARRAY_SIZE  per-column operand-B FIFO empty flags.
- a_pop  out  ARRAY_SIZE  per-row A FIFO pop / array A-lane valid.
- b_pop  out  ARRAY_SIZE  per-column B FIFO pop / array B-lane valid.
- array_clear  out  1  clear all PE accumulators.
- busy  out  1  tile in progress.
- done  out  1  one-cycle tile-complete pulse.

Function
REQ-003 FSM SHALL have states IDLE, CLEAR, FEED, DRAIN, DONE; busy = (state != IDLE).
REQ-004 IDLE with start=1 SHALL latch k_len into K and go to CLEAR next cycle; start outside IDLE SHALL be ignored.
REQ-005 CLEAR SHALL last exactly one cycle with array_clear=1, then go to FEED with step counter t=0; with K=0, CLEAR SHALL go directly to DONE (no pops).
REQ-006 In FEED, lane i SHALL be active when i <= t < i+K; same mask for row i of A and column i of B.
REQ-007 stall SHALL = any active lane i with a_empty[i] or b_empty[i] set.
REQ-008 a_pop[i]/b_pop[i] SHALL = active(i) and not stall, combinational from registered state/t and empty flags; inactive lanes SHALL never pop.
REQ-009 On a stall cycle, no lane SHALL pop and t SHALL hold; otherwise t SHALL increment by 1.
REQ-010 FEED SHALL end after the cycle in which t = K+ARRAY_SIZE-2 advances; next state DRAIN with drain counter 0.
REQ-011 DRAIN SHALL last exactly ARRAY_SIZE cycles (no pops), then DONE.
REQ-012 DONE SHALL last one cycle with done=1, then IDLE; a start in the DONE cycle SHALL be ignored.
REQ-013 Unstalled tile latency, start sample to done: 1 (CLEAR) + K+ARRAY_SIZE-1 (FEED) + ARRAY_SIZE (DRAIN) + 1 cycle, done asserted in last.
REQ-014 t SHALL be K_WIDTH+1 bits wide so K+ARRAY_SIZE-2 never wraps; total pops per lane per tile SHALL equal K exactly.

Reset
REQ-015 rst=1 at a clock edge SHALL force IDLE, t=0, drain counter 0, K=0; all outputs 0 from that edge on, including mid-FEED/DRAIN (partial tile abandoned, no done).
REQ-016 start asserted together with rst SHALL be ignored.

Configuration
REQ-017 With SYSTOLIC_SCHED_PERF_EN defined, extra output stall_cycles (out, 32) SHALL count FEED stall cycles of the current tile, zeroed on accepted start and on rst, held after done, saturating at 2^32-1.
REQ-018 Without SYSTOLIC_SCHED_PERF_EN, port stall_cycles and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-019 Shared package systolic_pkg SHALL hold the FSM state encoding (IDLE=0, CLEAR=1, FEED=2, DRAIN=3, DONE=4, 3 bits) and default ARRAY_SIZE/K_WIDTH constants.
REQ-020 Skew-mask generation (t, K -> ARRAY_SIZE-bit active mask) SHALL be sub-module systolic_skew_mask, purely combinational; FSM and counters stay in the top.

Verification (ARRAY_SIZE=4, K_WIDTH=16)
REQ-021 K=3, FIFOs never empty, start at cycle 0 -> array_clear at cycle 1; pops at cycles 2..7: a_pop=0001,0011,0111,1110,1100,1000; DRAIN cycles 8..11; done cycle 12 only.
REQ-022 K=3, b_empty[1]=1 during cycles 3..4 -> a_pop=b_pop=0 at cycles 3,4; t holds; sequence resumes at cycle 5; done at cycle 14; PERF_EN build stall_cycles=2.
REQ-023 K=0 -> array_clear cycle 1, done cycle 2, no pop ever asserted.
REQ-024 K=3, rst=1 at cycle 5 (mid-FEED) -> cycle 6 all outputs 0, busy=0, no done; new start at cycle 8 with K=1 -> done at cycle 8+1+4+4+1=18.
REQ-025 start held high continuously with K=2 -> back-to-back tiles, each done exactly 1+5+4+1 cycles after its acceptance; start in DONE cycle ignored, next accepted first IDLE cycle after it.
REQ-026 K=65535, no stalls -> each lane pops exactly 65535 times, t reaches 65537 without wrap, done exactly once.
